// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - Morse transmitter: one ASCII char per handshake, timed key_out pattern
// Letters, digits and space; lowercase folded to uppercase; other bytes flagged on err and dropped.
module morse_encoder #(
    parameter int UNIT_TICKS = 10_000_000
) (
    input  logic       clk_100Mhz,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       err
);

    localparam int TW = $clog2(UNIT_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(UNIT_TICKS - 1);

    typedef enum logic [2:0] {IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP} state_t;

    // {supported, space, len[2:0], pattern[4:0]}; pattern left-aligned, MSB first, 1 = dash
    function automatic logic [9:0] encode(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
        encode = 10'b0;
        case (u)
            8'h20: encode = {2'b11, 3'd0, 5'b00000};
            "A": encode = {2'b10, 3'd2, 5'b01000};
            "B": encode = {2'b10, 3'd4, 5'b10000};
            "C": encode = {2'b10, 3'd4, 5'b10100};
            "D": encode = {2'b10, 3'd3, 5'b10000};
            "E": encode = {2'b10, 3'd1, 5'b00000};
            "F": encode = {2'b10, 3'd4, 5'b00100};
            "G": encode = {2'b10, 3'd3, 5'b11000};
            "H": encode = {2'b10, 3'd4, 5'b00000};
            "I": encode = {2'b10, 3'd2, 5'b00000};
            "J": encode = {2'b10, 3'd4, 5'b01110};
            "K": encode = {2'b10, 3'd3, 5'b10100};
            "L": encode = {2'b10, 3'd4, 5'b01000};
            "M": encode = {2'b10, 3'd2, 5'b11000};
            "N": encode = {2'b10, 3'd2, 5'b10000};
            "O": encode = {2'b10, 3'd3, 5'b11100};
            "P": encode = {2'b10, 3'd4, 5'b01100};
            "Q": encode = {2'b10, 3'd4, 5'b11010};
            "R": encode = {2'b10, 3'd3, 5'b01000};
            "S": encode = {2'b10, 3'd3, 5'b00000};
            "T": encode = {2'b10, 3'd1, 5'b10000};
            "U": encode = {2'b10, 3'd3, 5'b00100};
            "V": encode = {2'b10, 3'd4, 5'b00010};
            "W": encode = {2'b10, 3'd3, 5'b01100};
            "X": encode = {2'b10, 3'd4, 5'b10010};
            "Y": encode = {2'b10, 3'd4, 5'b10110};
            "Z": encode = {2'b10, 3'd4, 5'b11000};
            "0": encode = {2'b10, 3'd5, 5'b11111};
            "1": encode = {2'b10, 3'd5, 5'b01111};
            "2": encode = {2'b10, 3'd5, 5'b00111};
            "3": encode = {2'b10, 3'd5, 5'b00011};
            "4": encode = {2'b10, 3'd5, 5'b00001};
            "5": encode = {2'b10, 3'd5, 5'b00000};
            "6": encode = {2'b10, 3'd5, 5'b10000};
            "7": encode = {2'b10, 3'd5, 5'b11000};
            "8": encode = {2'b10, 3'd5, 5'b11100};
            "9": encode = {2'b10, 3'd5, 5'b11110};
            default: encode = 10'b0;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      unit_q, unit_d;
    logic [2:0]      elem_q, elem_d;
    logic [2:0]      len_q, len_d;
    logic [4:0]      pat_q, pat_d;
    logic            key_q, key_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    logic [9:0]      enc;
    logic [2:0]      unit_last;
    logic            cur_dash;
    logic            unit_done;

    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            unit_q  <= '0;
            elem_q  <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            key_q   <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            unit_q  <= unit_d;
            elem_q  <= elem_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            key_q   <= key_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        unit_d   = unit_q;
        elem_d   = elem_q;
        len_d    = len_q;
        pat_d    = pat_q;
        key_d    = key_q;
        ready_d  = ready_q;
        err_d    = 1'b0;
        enc      = encode(char_in);
        cur_dash = pat_q[3'd4 - elem_q];

        // index of the final unit of the current state
        case (state_q)
            MARK:     unit_last = cur_dash ? 3'd2 : 3'd0;
            CHAR_GAP: unit_last = 3'd2;
            WORD_GAP: unit_last = 3'd3;
            default:  unit_last = 3'd0;
        endcase
        unit_done = (tick_q == TICK_LAST) && (unit_q == unit_last);

        if (state_q != IDLE) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                unit_d = unit_q + 3'd1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                tick_d  = '0;
                unit_d  = '0;
                ready_d = 1'b1;
                if (char_valid && ready_q) begin
                    ready_d = 1'b0;
                    if (!enc[9]) begin
                        err_d = 1'b1;
                    end else if (enc[8]) begin
                        state_d = WORD_GAP;
                    end else begin
                        state_d = MARK;
                        key_d   = 1'b1;
                        len_d   = enc[7:5];
                        pat_d   = enc[4:0];
                        elem_d  = '0;
                    end
                end
            end
            MARK: begin
                if (unit_done) begin
                    tick_d = '0;
                    unit_d = '0;
                    key_d  = 1'b0;
                    if (elem_q == len_q - 3'd1) begin
                        state_d = CHAR_GAP;
                    end else begin
                        state_d = ELEM_GAP;
                        elem_d  = elem_q + 3'd1;
                    end
                end
            end
            ELEM_GAP: begin
                if (unit_done) begin
                    tick_d  = '0;
                    unit_d  = '0;
                    key_d   = 1'b1;
                    state_d = MARK;
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (unit_done) begin
                    tick_d  = '0;
                    unit_d  = '0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_out    = key_q;
    assign char_ready = ready_q;
    assign busy       = ~ready_q;
    assign err        = err_q;

endmodule

// File: tb/tb_morse_encoder.sv
// tb/tb_morse_encoder.sv - testbench for morse_encoder against a dot/dash string model
module tb_morse_encoder;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       err;

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    logic exp_q[$];
    bit   exp_unsup;

    morse_encoder #(.UNIT_TICKS(U)) dut (
        .clk_100Mhz (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic string code_of(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
        case (u)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
            "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
            "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
            "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
            "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
            "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
            "8": return "---.."; "9": return "----.";
            default: return "";
        endcase
    endfunction

    // Expected key_out per cycle after the handshake edge, one entry per busy cycle
    task automatic build(input logic [7:0] c);
        string s;
        exp_q.delete();
        exp_unsup = 1'b0;
        s = code_of(c);
        if (c == 8'h20) begin
            repeat (4 * U) exp_q.push_back(1'b0);
        end else if (s.len() == 0) begin
            exp_unsup = 1'b1;
            exp_q.push_back(1'b0);
        end else begin
            for (int k = 0; k < s.len(); k++) begin
                repeat ((s[k] == "-") ? 3 * U : U) exp_q.push_back(1'b1);
                if (k != s.len() - 1) repeat (U) exp_q.push_back(1'b0);
            end
            repeat (3 * U) exp_q.push_back(1'b0);
        end
    endtask

    // Entered just after a negedge; returns just after the negedge where ready is back
    task automatic send(input logic [7:0] c, input bit distract, input string name);
        build(c);
        check($sformatf("%s ready_before", name), char_ready, 1);
        char_in    = c;
        char_valid = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) char_valid = 1'b0;
            if (distract && i == 2) begin
                char_in    = "T";
                char_valid = 1'b1;
            end
            if (distract && i == 3) char_valid = 1'b0;
            check($sformatf("%s cyc%0d key/busy/err", name, i), {key_out, busy, err},
                  {exp_q[i], 1'b1, 1'(exp_unsup && i == 0)});
        end
        @(negedge clk);
        check($sformatf("%s end key/ready/err", name), {key_out, char_ready, err}, 3'b010);
    endtask

    initial begin
        logic [7:0] c;
        string pool;
        pool       = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789 abcdefghijklmnopqrstuvwxyz";
        reset      = 1'b1;
        char_valid = 1'b0;
        char_in    = 8'h00;
        repeat (3) @(negedge clk);
        check("reset key/ready/busy/err", {key_out, char_ready, busy, err}, 4'b0100);
        reset = 1'b0;
        @(negedge clk);
        check("idle key/ready/busy/err", {key_out, char_ready, busy, err}, 4'b0100);

        send("E", 1'b0, "E");
        send("A", 1'b0, "A");
        send("a", 1'b0, "a");
        send("0", 1'b0, "zero");
        send(8'h20, 1'b0, "space");
        send("#", 1'b0, "hash");
        send("E", 1'b1, "E_distract");

        char_in    = "T";
        char_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            char_valid = 1'b0;
            check($sformatf("T_abort cyc%0d key", i), key_out, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        check("T_abort key/ready/busy", {key_out, char_ready, busy}, 3'b010);
        reset = 1'b0;
        @(negedge clk);
        check("T_abort idle key", key_out, 0);
        send("E", 1'b0, "E_after_reset");

        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 1) == 0) c = pool[$urandom_range(0, pool.len() - 1)];
            else c = 8'($urandom_range(0, 255));
            send(c, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_%02h", r, c));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
